// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with relative branches and an
// optional hardware return-address stack (RAS) for call/return.
// Optional feature macro: PC_UNIT_RAS_EN (defined = RAS built; undefined =
// call behaves as load, ret behaves as sequential increment, RAS outputs tied off).
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_en,
  input  logic                         load,
  input  logic [WIDTH-1:0]             new_pc,
  input  logic                         branch,
  input  logic [WIDTH-1:0]             offset,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_err
);

  localparam int unsigned      PW     = $clog2(RAS_DEPTH);
  localparam int unsigned      CW     = PW + 1;
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_BRANCH,
    ACT_CALL,
    ACT_RET,
    ACT_SEQ
  } action_e;

  action_e          action;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] branch_pc;
  logic [WIDTH-1:0] ret_pc;
  logic [WIDTH-1:0] next_pc;

  assign seq_pc    = pc + STEP_V;
  assign branch_pc = pc + offset;

  // Select exactly one action per enabled cycle, by fixed priority.
  always_comb begin
    action = ACT_HOLD;
    if (write_en) begin
      if (load)        action = ACT_LOAD;
      else if (branch) action = ACT_BRANCH;
      else if (call)   action = ACT_CALL;
      else if (ret)    action = ACT_RET;
      else             action = ACT_SEQ;
    end
  end

`ifdef PC_UNIT_RAS_EN
  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_m1;
  logic [CW-1:0]    count;
  logic             err;
  logic             push;
  logic             pop;
  logic             underflow;
  logic             overflow;
  logic             full;

  // top indexes the next free slot; when full it also indexes the oldest
  // entry, so an overflowing push overwrites the oldest without extra logic.
  assign top_m1 = top - 1'b1;
  assign full   = (count == CW'(RAS_DEPTH));

  // Decode stack operations from the selected action.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    overflow  = 1'b0;
    ret_pc    = seq_pc;
    if (action == ACT_CALL) begin
      push     = 1'b1;
      overflow = full;
    end
    if (action == ACT_RET) begin
      if (count != '0) begin
        pop    = 1'b1;
        ret_pc = stack[top_m1];
      end else begin
        underflow = 1'b1;
      end
    end
  end

  // Stack pointer, saturating count and registered error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      err <= overflow | underflow;
      if (push) begin
        top <= top + 1'b1;
        if (!full) count <= count + 1'b1;
      end else if (pop) begin
        top   <= top_m1;
        count <= count - 1'b1;
      end
    end
  end

  // Stack storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) stack[top] <= seq_pc;
  end

  assign ras_count = count;
  assign ras_empty = (count == '0);
  assign ras_full  = full;
  assign ras_err   = err;
`else
  assign ret_pc    = seq_pc;
  assign ras_count = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  // Next-PC mux.
  always_comb begin
    next_pc = pc;
    case (action)
      ACT_HOLD:   next_pc = pc;
      ACT_LOAD:   next_pc = new_pc;
      ACT_BRANCH: next_pc = branch_pc;
      ACT_CALL:   next_pc = new_pc;
      ACT_RET:    next_pc = ret_pc;
      ACT_SEQ:    next_pc = seq_pc;
      default:    next_pc = pc;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_VEC;
    else        pc <= next_pc;
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector self-checking bench for pc_unit (default params).
// Expectations follow PC_UNIT_RAS_EN so the bench suits either build.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic        load;
  logic [31:0] new_pc;
  logic        branch;
  logic [31:0] offset;
  logic        call;
  logic        ret;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int unsigned n_checks;
  int unsigned n_fails;

  pc_unit #(
    .WIDTH(32),
    .STEP(4),
    .RESET_VEC(32'h0),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .write_en(write_en),
    .load(load),
    .new_pc(new_pc),
    .branch(branch),
    .offset(offset),
    .call(call),
    .ret(ret),
    .pc(pc),
    .ras_count(ras_count),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_err(ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic ld, input logic br, input logic cl,
                       input logic rt, input logic [31:0] npc, input logic [31:0] off);
    write_en = we;
    load     = ld;
    branch   = br;
    call     = cl;
    ret      = rt;
    new_pc   = npc;
    offset   = off;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] call_pcs [5];
  logic [31:0] ret_exp  [4];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_count", 32'(ras_count), 32'd0);
    check("rst_empty", 32'(ras_empty), 32'd1);
    check("rst_full", 32'(ras_full), 32'd0);
    check("rst_err", 32'(ras_err), 32'd0);
    reset = 1'b1;

    // Run to 0x100, then asynchronous reset between edges
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    tick();
    check("load_100", pc, 32'h100);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #2;
    check("async_rst_pc", pc, 32'h0);
    reset = 1'b1;
    tick();
    check("post_rst_seq1", pc, 32'h4);
    tick();
    check("post_rst_seq2", pc, 32'h8);

    // Stall for 3 cycles with requests pending: everything ignored
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h900, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", pc, 32'h8);
    end
    check("stall_count", 32'(ras_count), 32'd0);
    check("stall_err", 32'(ras_err), 32'd0);

    // Wrap-around
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    tick();
    check("load_top", pc, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("wrap", pc, 32'h0);

    // Relative branch, then load overriding branch
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8);
    tick();
    check("branch_neg", pc, 32'h18);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFF8);
    tick();
    check("load_over_branch", pc, 32'h200);

    // Call / return
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    check("call_pc", pc, 32'h400);
`ifdef PC_UNIT_RAS_EN
    check("call_count", 32'(ras_count), 32'd1);
    check("call_empty", 32'(ras_empty), 32'd0);
`else
    check("call_count", 32'(ras_count), 32'd0);
    check("call_empty", 32'(ras_empty), 32'd1);
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
`ifdef PC_UNIT_RAS_EN
    check("ret_pc", pc, 32'h14);
`else
    check("ret_pc", pc, 32'h404);
`endif
    check("ret_count", 32'(ras_count), 32'd0);
    check("ret_empty", 32'(ras_empty), 32'd1);
    check("ret_err", 32'(ras_err), 32'd0);

    // Load+call: no push
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0);
    tick();
    check("loadcall_pc", pc, 32'h700);
    check("loadcall_count", 32'(ras_count), 32'd0);

    // Five nested calls from A..E, then five returns
    call_pcs[0] = 32'h1000; call_pcs[1] = 32'h2000; call_pcs[2] = 32'h3000;
    call_pcs[3] = 32'h4000; call_pcs[4] = 32'h5000;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, call_pcs[i] + 32'h1000, 32'h0);
      tick();
      check("nest_call_pc", pc, call_pcs[i] + 32'h1000);
`ifdef PC_UNIT_RAS_EN
      check("nest_err", 32'(ras_err), (i == 4) ? 32'd1 : 32'd0);
      check("nest_count", 32'(ras_count), (i >= 3) ? 32'd4 : 32'(i + 1));
      check("nest_full", 32'(ras_full), (i >= 3) ? 32'd1 : 32'd0);
`else
      check("nest_err", 32'(ras_err), 32'd0);
      check("nest_count", 32'(ras_count), 32'd0);
`endif
    end
    ret_exp[0] = 32'h5004; ret_exp[1] = 32'h4004;
    ret_exp[2] = 32'h3004; ret_exp[3] = 32'h2004;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
`ifdef PC_UNIT_RAS_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nest_ret_pc", pc, ret_exp[i]);
      check("nest_ret_err", 32'(ras_err), 32'd0);
      check("nest_ret_count", 32'(ras_count), 32'(3 - i));
    end
    tick();
    check("underflow_pc", pc, 32'h2008);
    check("underflow_err", 32'(ras_err), 32'd1);
    check("underflow_count", 32'(ras_count), 32'd0);
`else
    tick();
    check("off_ret_pc", pc, 32'h6004);
    check("off_ret_err", 32'(ras_err), 32'd0);
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("err_not_sticky", 32'(ras_err), 32'd0);

    // Reset right after a call discards the stack
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h0);
    tick();
    reset = 1'b0;
    #2;
    check("midcall_rst_pc", pc, 32'h0);
    check("midcall_rst_count", 32'(ras_count), 32'd0);
    check("midcall_rst_empty", 32'(ras_empty), 32'd1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("midcall_after", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
